// File: rtl/layer_serializer_if.sv
// Bus between a neuron layer's parallel outputs and the next layer's serial input.
// The master side drives the neuron vector; the slave side (serializer) drives the stream.
interface layer_serializer_if #(
    parameter int NEURON_NUM = 96,
    parameter int OUTPUT_W   = 8,
    parameter int INPUT_W    = 16
);
    logic [NEURON_NUM*OUTPUT_W-1:0] nrn_dat;
    logic [NEURON_NUM-1:0]          nrn_valid;
    logic [INPUT_W-1:0]             out_dat;
    logic                           out_valid;
    logic                           busy;
    logic                           err_drop;
    logic                           err_align;

    modport master (
        output nrn_dat, nrn_valid,
        input  out_dat, out_valid, busy, err_drop, err_align
    );

    modport slave (
        input  nrn_dat, nrn_valid,
        output out_dat, out_valid, busy, err_drop, err_align
    );
endinterface

// File: rtl/layer_serializer.sv
// Double-banked capture of one layer's parallel neuron outputs, replayed as a
// gap-free, sign-extended serial stream to every neuron of the next layer.
module layer_serializer #(
    parameter int NEURON_NUM = 96,
    parameter int OUTPUT_W   = 8,
    parameter int INPUT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    layer_serializer_if.slave bus
);
    localparam int IDX_W = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                               state;
    logic [IDX_W-1:0]                     idx;
    logic [1:0]                           full;
    logic                                 wr_ptr;
    logic                                 rd_ptr;
    logic [NEURON_NUM-1:0][OUTPUT_W-1:0]  bank [2];

    logic                                 cap;
    logic                                 misalign;
    logic                                 cap_ok;
    logic                                 cap_bank;
    logic                                 last;
    logic [1:0]                           full_nxt;
    logic [OUTPUT_W-1:0]                  word;

    // Capture is judged on pre-edge occupancy: a bank released on this edge still counts as full.
    always_comb begin
        cap      = &bus.nrn_valid;
        misalign = |bus.nrn_valid & ~&bus.nrn_valid;
        cap_ok   = cap & ~&full;
        cap_bank = (full == 2'b00) ? wr_ptr : full[0];
        last     = (state == STREAM) && (idx == IDX_W'(NEURON_NUM - 1));
        full_nxt = full;
        if (last)
            full_nxt[rd_ptr] = 1'b0;
        if (cap_ok)
            full_nxt[cap_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (cap_ok)
            bank[cap_bank] <= bus.nrn_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            full          <= 2'b00;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.err_drop  <= 1'b0;
            bus.err_align <= 1'b0;
        end else begin
            full <= full_nxt;
            if (cap_ok)
                wr_ptr <= ~wr_ptr;
            if (cap && !cap_ok)
                bus.err_drop <= 1'b1;
            if (misalign)
                bus.err_align <= 1'b1;

            case (state)
                IDLE: begin
                    // A capture into the read bank starts streaming on the same edge.
                    if (full_nxt[rd_ptr]) begin
                        state         <= STREAM;
                        idx           <= '0;
                        bus.out_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (last) begin
                        rd_ptr <= ~rd_ptr;
                        idx    <= '0;
                        if (!full_nxt[~rd_ptr]) begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign word        = bank[rd_ptr][idx];
    // Zero when idle so downstream multipliers stay quiet.
    assign bus.out_dat = bus.out_valid ? {{(INPUT_W-OUTPUT_W){word[OUTPUT_W-1]}}, word} : '0;
    assign bus.busy    = |full;
endmodule
